// File: rtl/datapath_pkg.sv
// Shared definitions for the two-stage datapath: function-select codes, FSM states, flag bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package datapath_pkg;

    // Function-select codes
    localparam logic [3:0] FS_A     = 4'b0000;
    localparam logic [3:0] FS_INC   = 4'b0001;
    localparam logic [3:0] FS_ADD   = 4'b0010;
    localparam logic [3:0] FS_ADD1  = 4'b0011;
    localparam logic [3:0] FS_ADDNB = 4'b0100;
    localparam logic [3:0] FS_SUB   = 4'b0101;
    localparam logic [3:0] FS_DEC   = 4'b0110;
    localparam logic [3:0] FS_A2    = 4'b0111;
    localparam logic [3:0] FS_AND   = 4'b1000;
    localparam logic [3:0] FS_OR    = 4'b1001;
    localparam logic [3:0] FS_XOR   = 4'b1010;
    localparam logic [3:0] FS_NOT   = 4'b1011;
    localparam logic [3:0] FS_B     = 4'b1100;
    localparam logic [3:0] FS_SHR   = 4'b1101;
    localparam logic [3:0] FS_SHL   = 4'b1110;
    localparam logic [3:0] FS_SHLN  = 4'b1111;

    // Issue FSM: SHIFT only while a multi-bit shift is iterating
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit positions inside the 4-bit status-flag vector
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/datapath_regfile.sv
// Register file: 2^RAW x NBIT, two async read ports, one sync write port, async clear.
// Latency: reads combinational; write visible the cycle after wr_en.
// Backpressure: none, accepts a write every cycle.
//
// Ports: clk_main/reset       clock, async active-high clear
//        wr_en/wr_addr/wr_dat write port
//        rd_a_*/rd_b_*        read ports (address in, data out)
module datapath_regfile
    import datapath_pkg::*;
#(
    parameter int NBIT = 16,
    parameter int RAW  = 4
) (
    input  logic            clk_main,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [RAW-1:0]  wr_addr,
    input  logic [NBIT-1:0] wr_dat,
    input  logic [RAW-1:0]  rd_a_addr,
    output logic [NBIT-1:0] rd_a_dat,
    input  logic [RAW-1:0]  rd_b_addr,
    output logic [NBIT-1:0] rd_b_dat
);

    localparam int NREG = 1 << RAW;

    logic [NBIT-1:0] regs_q [NREG];
    logic [NBIT-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_dat = regs_q[rd_a_addr];
    assign rd_b_dat = regs_q[rd_b_addr];

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: issue (operand read/forward, ALU, iterative shifter) and registered write-back.
// Latency: 1 cycle issue-to-retire; multi-bit shift by k retires k+1 cycles after acceptance.
// Backpressure: op_ready drops for the k busy cycles of a multi-bit shift; otherwise one op per cycle.
//
// Ports: clk_main/reset             clock, async active-high reset
//        op_valid/op_ready          micro-op handshake; DR SA SB FS MB MD RW MW const_in data_in fields
//        BusA/DataOut/mem_write     memory address, write data, write strobe
//        result_valid/result        retiring op and its write-back value
//        V C N Z                    status flags of the last retired op
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter int NBIT = 16,
    parameter int RAW  = 4,
    parameter int SHW  = $clog2(NBIT)
) (
    input  logic            clk_main,
    input  logic            reset,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [RAW-1:0]  DR,
    input  logic [RAW-1:0]  SA,
    input  logic [RAW-1:0]  SB,
    input  logic [3:0]      FS,
    input  logic            MB,
    input  logic            MD,
    input  logic            RW,
    input  logic            MW,
    input  logic [NBIT-1:0] const_in,
    input  logic [NBIT-1:0] data_in,
    output logic [NBIT-1:0] BusA,
    output logic [NBIT-1:0] DataOut,
    output logic            mem_write,
    output logic            result_valid,
    output logic [NBIT-1:0] result,
    output logic            V,
    output logic            C,
    output logic            N,
    output logic            Z
);

    typedef struct packed {
        logic            vld;
        logic            rw;
        logic [RAW-1:0]  dr;
        logic [NBIT-1:0] res;
    } wstage_t;

    // Everything a multi-bit shift needs after acceptance, frozen at issue
    typedef struct packed {
        logic [NBIT-1:0] dat;
        logic [SHW-1:0]  cnt;
        logic [RAW-1:0]  dr;
        logic            rw;
        logic            md;
        logic [NBIT-1:0] din;
    } shctx_t;

    state_e          state_q, state_d;
    wstage_t         w_q, w_d;
    shctx_t          sh_q, sh_d;
    logic [3:0]      flags_q, flags_d;

    logic [NBIT-1:0] rd_a, rd_b;
    logic [NBIT-1:0] a_op, b_reg, b_op;
    logic            fwd_a, fwd_b;
    logic            accept, start_shift, shift_last;
    logic [SHW-1:0]  shamt;

    logic [NBIT-1:0] fu_res;
    logic            fu_c, fu_v;
    logic            is_arith, arith_cin;
    logic [NBIT-1:0] arith_bx;
    logic [NBIT:0]   sum;

    logic [NBIT-1:0] shl_res;
    logic            shl_c;

    function automatic logic [3:0] mk_flags(input logic [NBIT-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = r[NBIT-1];
        f[FLAG_Z] = (r == '0);
        return f;
    endfunction

    datapath_regfile #(
        .NBIT (NBIT),
        .RAW  (RAW)
    ) u_regfile (
        .clk_main  (clk_main),
        .reset     (reset),
        .wr_en     (w_q.vld & w_q.rw),
        .wr_addr   (w_q.dr),
        .wr_dat    (w_q.res),
        .rd_a_addr (SA),
        .rd_a_dat  (rd_a),
        .rd_b_addr (SB),
        .rd_b_dat  (rd_b)
    );

    // Bypass the write-back stage: the regfile only sees W's value one edge later
    assign fwd_a = w_q.vld & w_q.rw & (w_q.dr == SA);
    assign fwd_b = w_q.vld & w_q.rw & (w_q.dr == SB);
    assign a_op  = fwd_a ? w_q.res : rd_a;
    assign b_reg = fwd_b ? w_q.res : rd_b;
    assign b_op  = MB ? const_in : b_reg;

    assign BusA      = a_op;
    assign DataOut   = b_op;
    assign accept    = op_valid & op_ready;
    assign mem_write = accept & MW;

    assign shamt       = b_op[SHW-1:0];
    assign start_shift = accept & (FS == FS_SHLN) & (shamt != '0);
    assign shift_last  = (state_q == ST_SHIFT) & (sh_q.cnt == SHW'(1));
    assign shl_res     = {sh_q.dat[NBIT-2:0], 1'b0};
    assign shl_c       = sh_q.dat[NBIT-1];

    // Function unit
    always_comb begin
        fu_res    = '0;
        fu_c      = 1'b0;
        fu_v      = 1'b0;
        is_arith  = 1'b0;
        arith_bx  = '0;
        arith_cin = 1'b0;
        sum       = '0;
        case (FS)
            FS_A, FS_A2: is_arith = 1'b1;
            FS_INC:   begin is_arith = 1'b1; arith_cin = 1'b1; end
            FS_ADD:   begin is_arith = 1'b1; arith_bx = b_op; end
            FS_ADD1:  begin is_arith = 1'b1; arith_bx = b_op; arith_cin = 1'b1; end
            FS_ADDNB: begin is_arith = 1'b1; arith_bx = ~b_op; end
            FS_SUB:   begin is_arith = 1'b1; arith_bx = ~b_op; arith_cin = 1'b1; end
            FS_DEC:   begin is_arith = 1'b1; arith_bx = '1; end
            FS_AND:   fu_res = a_op & b_op;
            FS_OR:    fu_res = a_op | b_op;
            FS_XOR:   fu_res = a_op ^ b_op;
            FS_NOT:   fu_res = ~a_op;
            FS_B:     fu_res = b_op;
            FS_SHR:   begin fu_res = {1'b0, b_op[NBIT-1:1]}; fu_c = b_op[0]; end
            FS_SHL:   begin fu_res = {b_op[NBIT-2:0], 1'b0}; fu_c = b_op[NBIT-1]; end
            // Only the zero-amount case retires from here; nonzero amounts go to the shifter
            FS_SHLN:  fu_res = a_op;
            default:  fu_res = '0;
        endcase
        sum = {1'b0, a_op} + {1'b0, arith_bx} + {{NBIT{1'b0}}, arith_cin};
        if (is_arith) begin
            fu_res = sum[NBIT-1:0];
            fu_c   = sum[NBIT];
            fu_v   = (a_op[NBIT-1] == arith_bx[NBIT-1]) & (sum[NBIT-1] != a_op[NBIT-1]);
        end
    end

    // FSM: state register
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_shift) state_d = ST_SHIFT;
            ST_SHIFT: if (shift_last)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        op_ready = (state_q == ST_IDLE);
    end

    // Shifter context
    always_comb begin
        sh_d = sh_q;
        if (start_shift) begin
            sh_d.dat = a_op;
            sh_d.cnt = shamt;
            sh_d.dr  = DR;
            sh_d.rw  = RW;
            sh_d.md  = MD;
            sh_d.din = data_in;
        end else if (state_q == ST_SHIFT) begin
            sh_d.dat = shl_res;
            sh_d.cnt = sh_q.cnt - SHW'(1);
        end
    end

    // Write-back stage and flags; vld is a one-cycle pulse per retiring op
    always_comb begin
        w_d     = w_q;
        w_d.vld = 1'b0;
        flags_d = flags_q;
        if (accept && !start_shift) begin
            w_d.vld = 1'b1;
            w_d.rw  = RW;
            w_d.dr  = DR;
            w_d.res = MD ? data_in : fu_res;
            flags_d = mk_flags(fu_res, fu_c, fu_v);
        end else if (shift_last) begin
            w_d.vld = 1'b1;
            w_d.rw  = sh_q.rw;
            w_d.dr  = sh_q.dr;
            w_d.res = sh_q.md ? sh_q.din : shl_res;
            flags_d = mk_flags(shl_res, shl_c, 1'b0);
        end
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            w_q     <= '0;
            sh_q    <= '0;
            flags_q <= '0;
        end else begin
            w_q     <= w_d;
            sh_q    <= sh_d;
            flags_q <= flags_d;
        end
    end

    assign result_valid = w_q.vld;
    assign result       = w_q.res;
    assign V            = flags_q[FLAG_V];
    assign C            = flags_q[FLAG_C];
    assign N            = flags_q[FLAG_N];
    assign Z            = flags_q[FLAG_Z];

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed micro-ops, expected results queued at issue, checked on retire.
// Latency: follows DUT (1 cycle, k+1 for multi-bit shifts).
// Backpressure: stimulus holds op_valid until op_ready, bounded wait.
module tb_datapath_pipe;
    import datapath_pkg::*;

    localparam int NBIT = 16;
    localparam int RAW  = 4;

    logic            clk_main = 1'b0;
    logic            reset;
    logic            op_valid;
    logic            op_ready;
    logic [RAW-1:0]  DR, SA, SB;
    logic [3:0]      FS;
    logic            MB, MD, RW, MW;
    logic [NBIT-1:0] const_in, data_in;
    logic [NBIT-1:0] BusA, DataOut;
    logic            mem_write;
    logic            result_valid;
    logic [NBIT-1:0] result;
    logic            V, C, N, Z;

    always #5 clk_main = ~clk_main;

    datapath_pipe #(.NBIT(NBIT), .RAW(RAW)) dut (
        .clk_main     (clk_main),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .DR           (DR),
        .SA           (SA),
        .SB           (SB),
        .FS           (FS),
        .MB           (MB),
        .MD           (MD),
        .RW           (RW),
        .MW           (MW),
        .const_in     (const_in),
        .data_in      (data_in),
        .BusA         (BusA),
        .DataOut      (DataOut),
        .mem_write    (mem_write),
        .result_valid (result_valid),
        .result       (result),
        .V            (V),
        .C            (C),
        .N            (N),
        .Z            (Z)
    );

    int total = 0;
    int bad   = 0;

    logic [NBIT-1:0] exp_res_q [$];
    logic [3:0]      exp_flg_q [$];
    string           exp_nam_q [$];

    logic [NBIT-1:0] mon_res;
    logic [3:0]      mon_flg;
    string           mon_nam;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every retirement must match the oldest queued expectation
    always @(negedge clk_main) begin
        if (result_valid === 1'b1) begin
            if (exp_res_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got result 0x%0h, need no retirement", result);
            end else begin
                mon_res = exp_res_q.pop_front();
                mon_flg = exp_flg_q.pop_front();
                mon_nam = exp_nam_q.pop_front();
                chk({"res_", mon_nam}, 32'(result), 32'(mon_res));
                chk({"flags_", mon_nam}, 32'({V, C, N, Z}), 32'(mon_flg));
            end
        end
    end

    // Drive one op, hold it until accepted (bounded), optionally queue its expected retirement
    task automatic issue(input string nm, input logic [3:0] dr, sa, sb, fs,
                         input logic mb, md, rw, input logic [15:0] kc, din, er,
                         input logic [3:0] ef, input bit push);
        int n;
        if (push) begin
            exp_res_q.push_back(er);
            exp_flg_q.push_back(ef);
            exp_nam_q.push_back(nm);
        end
        DR = dr; SA = sa; SB = sb; FS = fs;
        MB = mb; MD = md; RW = rw; MW = 1'b0;
        const_in = kc; data_in = din;
        op_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk_main);
            n++;
        end while (op_ready !== 1'b1 && n < 50);
        chk({"accept_", nm}, 32'(op_ready), 32'd1);
        @(posedge clk_main);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_main);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b0; op_valid = 1'b0;
        DR = '0; SA = '0; SB = '0; FS = '0;
        MB = 0; MD = 0; RW = 0; MW = 0;
        const_in = '0; data_in = '0;
        #2 reset = 1'b1;
        #2;
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_flags", 32'({V, C, N, Z}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        repeat (2) @(posedge clk_main);
        @(negedge clk_main) reset = 1'b0;
        idle(1);

        // Forwarding: R1 = 5, then R2 = R1 + R1 the very next cycle
        issue("ld_r1",   1, 0, 0, FS_B,   1, 0, 1, 16'h0005, 0, 16'h0005, 4'b0000, 1);
        issue("fwd_add", 2, 1, 1, FS_ADD, 0, 0, 1, 0,        0, 16'h000A, 4'b0000, 1);
        idle(1);
        issue("rd_r2",   0, 2, 0, FS_A,   0, 0, 0, 0,        0, 16'h000A, 4'b0000, 1);

        // Subtract to zero (A from regfile, B forwarded)
        issue("ld_r3",   3, 0, 0, FS_B,   1, 0, 1, 16'h1234, 0, 16'h1234, 4'b0000, 1);
        issue("ld_r4",   4, 0, 0, FS_B,   1, 0, 1, 16'h1234, 0, 16'h1234, 4'b0000, 1);
        issue("sub0",    5, 3, 4, FS_SUB, 0, 0, 1, 0,        0, 16'h0000, 4'b0101, 1);

        // Signed overflow
        issue("ld_r6",   6, 0, 0, FS_B,   1, 0, 1, 16'h7FFF, 0, 16'h7FFF, 4'b0000, 1);
        issue("ovf",     7, 6, 0, FS_ADD, 1, 0, 1, 16'h0001, 0, 16'h8000, 4'b1010, 1);

        // Logic and single-bit shifts
        issue("and",     0, 3, 0, FS_AND, 1, 0, 0, 16'h00FF, 0, 16'h0034, 4'b0000, 1);
        issue("xor",     0, 3, 4, FS_XOR, 0, 0, 0, 0,        0, 16'h0000, 4'b0001, 1);
        issue("shr",     0, 0, 0, FS_SHR, 1, 0, 0, 16'h0003, 0, 16'h0001, 4'b0100, 1);
        issue("shl",     0, 0, 0, FS_SHL, 1, 0, 0, 16'h8001, 0, 16'h0002, 4'b0100, 1);
        issue("dec0",    0, 5, 0, FS_DEC, 0, 0, 0, 0,        0, 16'hFFFF, 4'b0010, 1);

        // Multi-cycle shift with an op held while busy
        issue("ld_r8",   8, 0, 0, FS_B,   1, 0, 1, 16'h0003, 0, 16'h0003, 4'b0000, 1);
        issue("ld_r11", 11, 0, 0, FS_B,   1, 0, 1, 16'hF000, 0, 16'hF000, 4'b0010, 1);
        issue("shift4",  9, 8, 0, FS_SHLN, 1, 0, 1, 16'd4,   0, 16'h0030, 4'b0000, 1);
        fork
            issue("held", 10, 9, 0, FS_A, 0, 0, 1, 0, 0, 16'h0030, 4'b0000, 1);
            begin
                for (int i = 1; i <= 4; i++) begin
                    @(negedge clk_main);
                    chk($sformatf("busy_cycle_%0d", i), 32'(op_ready), 32'd0);
                end
                @(negedge clk_main);
                chk("ready_back_t5", 32'(op_ready), 32'd1);
                chk("shift_rv_t5", 32'(result_valid), 32'd1);
            end
        join
        issue("shift1", 12, 11, 0, FS_SHLN, 1, 0, 1, 16'd1, 0, 16'hE000, 4'b0110, 1);
        issue("shift0", 13,  8, 0, FS_SHLN, 1, 0, 1, 16'd0, 0, 16'h0003, 4'b0000, 1);

        // Memory write: address from R3, data from R6
        exp_res_q.push_back(16'h1234); exp_flg_q.push_back(4'b0000); exp_nam_q.push_back("mem_wr");
        DR = 0; SA = 3; SB = 6; FS = FS_A; MB = 0; MD = 0; RW = 0; MW = 1;
        const_in = '0; data_in = '0; op_valid = 1'b1;
        @(negedge clk_main);
        chk("mem_write_on", 32'(mem_write), 32'd1);
        chk("mem_busa", 32'(BusA), 32'h1234);
        chk("mem_dataout", 32'(DataOut), 32'h7FFF);
        @(posedge clk_main);
        #1 op_valid = 1'b0;
        @(negedge clk_main);
        chk("mem_write_off", 32'(mem_write), 32'd0);
        MW = 0;
        idle(1);

        // Memory read into R12; flags still come from the function unit
        issue("md_load", 12, 3, 0, FS_B, 1, 1, 1, 16'h0000, 16'hBEEF, 16'hBEEF, 4'b0001, 1);
        idle(1);
        issue("rd_r12",  0, 12, 0, FS_A, 0, 0, 0, 0, 0, 16'hBEEF, 4'b0010, 1);

        // Reset during SHIFT: in-flight op discarded, everything cleared
        issue("ld_r5",   5, 0, 0, FS_B, 1, 0, 1, 16'h80FF, 0, 16'h80FF, 4'b0010, 1);
        issue("shift_rst", 5, 8, 0, FS_SHLN, 1, 0, 1, 16'd8, 0, 16'h0000, 4'b0000, 0);
        @(negedge clk_main);
        chk("busy_before_rst", 32'(op_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_op_ready", 32'(op_ready), 32'd1);
        chk("midrst_flags", 32'({V, C, N, Z}), 32'd0);
        chk("midrst_result_valid", 32'(result_valid), 32'd0);
        @(posedge clk_main);
        #1 reset = 1'b0;
        idle(3);
        issue("rd_r5", 0, 5, 0, FS_A, 0, 0, 0, 0, 0, 16'h0000, 4'b0001, 1);

        n = 0;
        while (exp_res_q.size() > 0 && n < 20) begin
            @(posedge clk_main);
            n++;
        end
        @(negedge clk_main);
        chk("drain_empty", 32'(exp_res_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
